// File: rtl/lm96570_spi_mc.sv
// Parallel serial programming engine for a bank of LM96570 pulser chips:
// shared SCLK, per-device data/load-enable, simultaneous LSB-first readback.
module lm96570_spi_mc #(
    parameter int MAX_BITS = 70,
    parameter int NUM_DEV  = 4,
    parameter int CLK_DIV  = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         start,
    input  logic [7:0]                   num_of_bits,
    input  logic [NUM_DEV-1:0]           dev_mask,
    input  logic [NUM_DEV*MAX_BITS-1:0]  din,
    output logic [NUM_DEV*MAX_BITS-1:0]  dout,
    output logic                         busy,
    output logic                         done,
    output logic                         spi_sclk,
    output logic [NUM_DEV-1:0]           spi_sle,
    output logic [NUM_DEV-1:0]           spi_sdi,
    input  logic [NUM_DEV-1:0]           spi_sdo,
    output logic [2:0]                   dbg_state
);

    localparam int IW = (MAX_BITS > 1) ? $clog2(MAX_BITS) : 1;
    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(CLK_DIV - 1);
    localparam logic [7:0]    MAX_N8   = 8'(MAX_BITS);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LOW  = 3'd1,
        S_HIGH = 3'd2,
        S_HOLD = 3'd3,
        S_FIN  = 3'd4
    } state_t;

    state_t                            r_state;
    logic [CW-1:0]                     r_cnt;
    logic [IW-1:0]                     r_idx;
    logic [IW:0]                       r_neff;
    logic [NUM_DEV-1:0]                r_mask;
    logic [NUM_DEV-1:0][MAX_BITS-1:0]  r_din;
    logic [NUM_DEV-1:0][MAX_BITS-1:0]  r_cap;
    logic [NUM_DEV-1:0][MAX_BITS-1:0]  r_dout;
    logic                              r_busy;
    logic                              r_done;
    logic                              r_sclk;
    logic [NUM_DEV-1:0]                r_sle;
    logic [NUM_DEV-1:0]                r_sdi;

    logic [NUM_DEV-1:0][MAX_BITS-1:0]  w_din_in;
    logic [NUM_DEV-1:0][MAX_BITS-1:0]  w_cap_next;
    logic [NUM_DEV-1:0]                w_first_sdi;
    logic [NUM_DEV-1:0]                w_next_sdi;
    logic [IW:0]                       w_neff_in;
    logic [IW-1:0]                     w_next_idx;
    logic                              w_cnt_done;
    logic                              w_last_bit;

    assign w_din_in   = din;
    assign w_neff_in  = (num_of_bits > MAX_N8) ? (IW+1)'(MAX_BITS) : (IW+1)'(num_of_bits);
    assign w_next_idx = r_idx + IW'(1);
    assign w_cnt_done = (r_cnt == CNT_LAST);
    assign w_last_bit = ({1'b0, r_idx} == (r_neff - (IW+1)'(1)));

    // Capture is gated by the latched mask so masked-off slices read back zero.
    for (genvar g = 0; g < NUM_DEV; g++) begin : g_dev
        assign w_first_sdi[g] = din[g*MAX_BITS] & dev_mask[g];
        assign w_next_sdi[g]  = r_din[g][w_next_idx] & r_mask[g];
        assign w_cap_next[g]  = r_cap[g] |
            ({{(MAX_BITS-1){1'b0}}, spi_sdo[g] & r_mask[g]} << r_idx);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_neff  <= '0;
            r_mask  <= '0;
            r_din   <= '0;
            r_cap   <= '0;
            r_dout  <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_sclk  <= 1'b0;
            r_sle   <= '0;
            r_sdi   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_din  <= w_din_in;
                        r_mask <= dev_mask;
                        r_neff <= w_neff_in;
                        r_idx  <= '0;
                        r_cnt  <= '0;
                        r_cap  <= '0;
                        if (w_neff_in == '0) begin
                            r_state <= S_FIN;
                            r_done  <= 1'b1;
                            r_dout  <= '0;
                        end else begin
                            r_state <= S_LOW;
                            r_busy  <= 1'b1;
                            r_sle   <= dev_mask;
                            r_sdi   <= w_first_sdi;
                        end
                    end
                end
                S_LOW: begin
                    if (w_cnt_done) begin
                        r_cnt   <= '0;
                        r_state <= S_HIGH;
                        r_sclk  <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                S_HIGH: begin
                    if (w_cnt_done) begin
                        r_cnt  <= '0;
                        r_cap  <= w_cap_next;
                        r_sclk <= 1'b0;
                        if (w_last_bit) begin
                            r_state <= S_HOLD;
                            r_sdi   <= '0;
                        end else begin
                            r_state <= S_LOW;
                            r_idx   <= w_next_idx;
                            r_sdi   <= w_next_sdi;
                        end
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                S_HOLD: begin
                    if (w_cnt_done) begin
                        r_cnt   <= '0;
                        r_state <= S_FIN;
                        r_sle   <= '0;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_dout  <= r_cap;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                S_FIN: begin
                    r_done  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign dout      = r_dout;
    assign busy      = r_busy;
    assign done      = r_done;
    assign spi_sclk  = r_sclk;
    assign spi_sle   = r_sle;
    assign spi_sdi   = r_sdi;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_lm96570_spi_mc.sv
// Scoreboard bench for lm96570_spi_mc: expected readback is queued at start
// and compared when done pulses; a negedge monitor counts pin activity.
module tb_lm96570_spi_mc;
  localparam int MB = 70;
  localparam int ND = 4;
  localparam int CD = 2;
  localparam int W  = ND * MB;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [7:0]    num_of_bits;
  logic [ND-1:0] dev_mask;
  logic [W-1:0]  din;
  logic [W-1:0]  dout;
  logic          busy;
  logic          done;
  logic          spi_sclk;
  logic [ND-1:0] spi_sle;
  logic [ND-1:0] spi_sdi;
  logic [ND-1:0] spi_sdo;
  logic [2:0]    dbg_state;

  logic          loop_en = 1'b0;
  logic [ND-1:0] sdo_drv = '0;
  assign spi_sdo = loop_en ? spi_sdi : sdo_drv;

  lm96570_spi_mc #(.MAX_BITS(MB), .NUM_DEV(ND), .CLK_DIV(CD)) dut (
    .clk(clk), .reset(reset), .start(start), .num_of_bits(num_of_bits),
    .dev_mask(dev_mask), .din(din), .dout(dout), .busy(busy), .done(done),
    .spi_sclk(spi_sclk), .spi_sle(spi_sle), .spi_sdi(spi_sdi),
    .spi_sdo(spi_sdo), .dbg_state(dbg_state)
  );

  // clock / watchdog
  always #5 clk = ~clk;
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int n_chk = 0;
  int n_pass = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] exp_v;

  // activity monitor
  int rise_cnt, sle0_cnt, sle_any_cnt, busy_cnt, done_cnt, stable_cnt;
  bit setup_bad, mask_bad;
  logic prev_sclk = 1'b0;
  logic [ND-1:0] prev_sdi = '0;
  logic [ND-1:0] mon_mask = '1;

  always @(negedge clk) begin
    if (spi_sclk === 1'b1 && prev_sclk !== 1'b1) begin
      rise_cnt++;
      if (stable_cnt < CD) setup_bad = 1'b1;
    end
    if (spi_sdi !== prev_sdi) stable_cnt = 1;
    else stable_cnt++;
    prev_sclk = spi_sclk;
    prev_sdi = spi_sdi;
    if (spi_sle[0] === 1'b1) sle0_cnt++;
    if (|spi_sle) sle_any_cnt++;
    if (busy === 1'b1) busy_cnt++;
    if (done === 1'b1) done_cnt++;
    if (|((spi_sle | spi_sdi) & ~mon_mask)) mask_bad = 1'b1;
  end

  task automatic clear_mon(input logic [ND-1:0] m);
    rise_cnt = 0; sle0_cnt = 0; sle_any_cnt = 0; busy_cnt = 0; done_cnt = 0;
    setup_bad = 1'b0; mask_bad = 1'b0; mon_mask = m;
  endtask

  function automatic logic [W-1:0] rand_vec();
    logic [W-1:0] v;
    for (int i = 0; i < W; i++) v[i] = 1'($urandom_range(0, 1));
    return v;
  endfunction

  function automatic logic [W-1:0] model(input logic [W-1:0] d, input logic [7:0] n,
                                         input logic [ND-1:0] m, input bit lp,
                                         input logic [ND-1:0] sc);
    logic [W-1:0] r;
    int ne;
    r = '0;
    ne = (int'(n) > MB) ? MB : int'(n);
    for (int dv = 0; dv < ND; dv++)
      for (int b = 0; b < ne; b++)
        if (m[dv]) r[dv*MB+b] = lp ? d[dv*MB+b] : sc[dv];
    return r;
  endfunction

  // driver: returns #1 after edge 0 (cycle 1); inputs are scrambled after acceptance
  task automatic start_xfer(input logic [7:0] n, input logic [ND-1:0] m,
                            input logic [W-1:0] d, input bit lp, input logic [ND-1:0] sc);
    exp_q.push_back(model(d, n, m, lp, sc));
    @(posedge clk); #1;
    loop_en = lp; sdo_drv = sc;
    num_of_bits = n; dev_mask = m; din = d; start = 1'b1;
    clear_mon(m);
    @(posedge clk); #1;
    start = 1'b0;
    num_of_bits = 8'($urandom_range(0, 255));
    dev_mask = ND'($urandom_range(0, 15));
    din = rand_vec();
  endtask

  task automatic wait_done(input int c0, output int cyc);
    cyc = c0;
    while (done !== 1'b1 && cyc < 3000) begin
      @(posedge clk); #1;
      cyc++;
    end
    if (done !== 1'b1) cyc = -1;
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; num_of_bits = '0; dev_mask = '0; din = '0;
    repeat (3) @(posedge clk);
    #1;
    n_chk++; if (spi_sclk !== 1'b0) $display("FAIL reset_sclk: got %b exp 0", spi_sclk); else n_pass++;
    n_chk++; if (spi_sle !== '0) $display("FAIL reset_sle: got %b exp 0", spi_sle); else n_pass++;
    n_chk++; if (spi_sdi !== '0) $display("FAIL reset_sdi: got %b exp 0", spi_sdi); else n_pass++;
    n_chk++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b exp 0", busy); else n_pass++;
    n_chk++; if (done !== 1'b0) $display("FAIL reset_done: got %b exp 0", done); else n_pass++;
    n_chk++; if (dout !== '0) $display("FAIL reset_dout: got %h exp 0", dout); else n_pass++;
    n_chk++; if (dbg_state !== 3'd0) $display("FAIL reset_state: got %0d exp 0", dbg_state); else n_pass++;
    reset = 1'b0;
  endtask

  task automatic test_single_70();
    logic [W-1:0] d;
    int cyc;
    d = rand_vec();
    d[MB-1:0] = 70'h2A_5555_AAAA_0F0F_F0F0;
    start_xfer(8'd70, 4'b0001, d, 1'b1, '0);
    n_chk++; if (busy !== 1'b1) $display("FAIL s70_busy_c1: got %b exp 1", busy); else n_pass++;
    wait_done(1, cyc);
    n_chk++; if (cyc != 283) $display("FAIL s70_done_cycle: got %0d exp 283", cyc); else n_pass++;
    n_chk++; if (busy !== 1'b0) $display("FAIL s70_busy_in_fin: got %b exp 0", busy); else n_pass++;
    n_chk++; if (rise_cnt != 70) $display("FAIL s70_pulses: got %0d exp 70", rise_cnt); else n_pass++;
    n_chk++; if (sle0_cnt != 282) $display("FAIL s70_sle_cycles: got %0d exp 282", sle0_cnt); else n_pass++;
    n_chk++; if (setup_bad) $display("FAIL s70_sdi_setup: got violation exp none"); else n_pass++;
    n_chk++; if (mask_bad) $display("FAIL s70_mask: got activity exp none"); else n_pass++;
    n_chk++; if (dout[MB-1:0] !== 70'h2A_5555_AAAA_0F0F_F0F0)
      $display("FAIL s70_dev0: got %h exp 2a5555aaaa0f0ff0f0", dout[MB-1:0]); else n_pass++;
    exp_v = exp_q.pop_front();
    n_chk++; if (dout !== exp_v) $display("FAIL s70_dout: got %h exp %h", dout, exp_v); else n_pass++;
  endtask

  task automatic test_partial_clamp();
    logic [W-1:0] d;
    int cyc;
    d = rand_vec();
    d[2*MB-1:MB] = '1;
    start_xfer(8'd6, 4'b1111, d, 1'b1, '0);
    wait_done(1, cyc);
    n_chk++; if (cyc != 27) $display("FAIL n6_done_cycle: got %0d exp 27", cyc); else n_pass++;
    n_chk++; if (rise_cnt != 6) $display("FAIL n6_pulses: got %0d exp 6", rise_cnt); else n_pass++;
    n_chk++; if (dout[2*MB-1:MB] !== 70'h3F) $display("FAIL n6_dev1: got %h exp 3f", dout[2*MB-1:MB]); else n_pass++;
    exp_v = exp_q.pop_front();
    n_chk++; if (dout !== exp_v) $display("FAIL n6_dout: got %h exp %h", dout, exp_v); else n_pass++;
    start_xfer(8'd200, 4'b1111, rand_vec(), 1'b1, '0);
    wait_done(1, cyc);
    n_chk++; if (cyc != 283) $display("FAIL n200_done_cycle: got %0d exp 283", cyc); else n_pass++;
    n_chk++; if (rise_cnt != 70) $display("FAIL n200_pulses: got %0d exp 70", rise_cnt); else n_pass++;
    exp_v = exp_q.pop_front();
    n_chk++; if (dout !== exp_v) $display("FAIL n200_dout: got %h exp %h", dout, exp_v); else n_pass++;
  endtask

  task automatic test_masking();
    int cyc;
    start_xfer(8'd8, 4'b1010, rand_vec(), 1'b0, 4'hF);
    wait_done(1, cyc);
    n_chk++; if (cyc != 35) $display("FAIL mask_done_cycle: got %0d exp 35", cyc); else n_pass++;
    n_chk++; if (mask_bad) $display("FAIL mask_activity: got activity on dev0/dev2 exp none"); else n_pass++;
    n_chk++; if (dout[2*MB-1:MB] !== 70'hFF) $display("FAIL mask_dev1: got %h exp ff", dout[2*MB-1:MB]); else n_pass++;
    n_chk++; if (dout[MB-1:0] !== '0) $display("FAIL mask_dev0: got %h exp 0", dout[MB-1:0]); else n_pass++;
    exp_v = exp_q.pop_front();
    n_chk++; if (dout !== exp_v) $display("FAIL mask_dout: got %h exp %h", dout, exp_v); else n_pass++;
  endtask

  task automatic test_zero_length();
    int cyc;
    start_xfer(8'd0, 4'b1111, rand_vec(), 1'b1, '0);
    wait_done(1, cyc);
    n_chk++; if (cyc != 1) $display("FAIL zero_done_cycle: got %0d exp 1", cyc); else n_pass++;
    exp_v = exp_q.pop_front();
    n_chk++; if (dout !== exp_v) $display("FAIL zero_dout: got %h exp %h", dout, exp_v); else n_pass++;
    repeat (4) begin @(posedge clk); #1; end
    n_chk++; if (busy_cnt != 0) $display("FAIL zero_busy: got %0d busy cycles exp 0", busy_cnt); else n_pass++;
    n_chk++; if (rise_cnt != 0 || sle_any_cnt != 0)
      $display("FAIL zero_activity: got %0d pulses %0d sle cycles exp 0", rise_cnt, sle_any_cnt); else n_pass++;
  endtask

  task automatic test_ignored_start();
    int cyc;
    start_xfer(8'd20, 4'b1111, rand_vec(), 1'b1, '0);
    repeat (9) begin @(posedge clk); #1; end
    num_of_bits = 8'd3; dev_mask = 4'b0001; din = rand_vec(); start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(11, cyc);
    n_chk++; if (cyc != 83) $display("FAIL ign_done_cycle: got %0d exp 83", cyc); else n_pass++;
    n_chk++; if (rise_cnt != 20) $display("FAIL ign_pulses: got %0d exp 20", rise_cnt); else n_pass++;
    exp_v = exp_q.pop_front();
    n_chk++; if (dout !== exp_v) $display("FAIL ign_dout: got %h exp %h", dout, exp_v); else n_pass++;
  endtask

  task automatic test_reset_abort();
    int k;
    int cyc;
    start_xfer(8'd20, 4'b1111, rand_vec(), 1'b1, '0);
    k = 0;
    while (rise_cnt < 10 && k < 500) begin @(posedge clk); #1; k++; end
    n_chk++; if (rise_cnt != 10) $display("FAIL abort_reach_bit10: got %0d pulses exp 10", rise_cnt); else n_pass++;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    void'(exp_q.pop_back());
    n_chk++; if (spi_sclk !== 1'b0 || spi_sle !== '0 || spi_sdi !== '0)
      $display("FAIL abort_pins: got sclk %b sle %b sdi %b exp all 0", spi_sclk, spi_sle, spi_sdi); else n_pass++;
    n_chk++; if (busy !== 1'b0) $display("FAIL abort_busy: got %b exp 0", busy); else n_pass++;
    n_chk++; if (dout !== '0) $display("FAIL abort_dout: got %h exp 0", dout); else n_pass++;
    done_cnt = 0;
    repeat (100) begin @(posedge clk); #1; end
    n_chk++; if (done_cnt != 0) $display("FAIL abort_no_done: got %0d done pulses exp 0", done_cnt); else n_pass++;
    start_xfer(8'd5, 4'b1111, rand_vec(), 1'b1, '0);
    wait_done(1, cyc);
    n_chk++; if (cyc != 23) $display("FAIL abort_fresh_cycle: got %0d exp 23", cyc); else n_pass++;
    exp_v = exp_q.pop_front();
    n_chk++; if (dout !== exp_v) $display("FAIL abort_fresh_dout: got %h exp %h", dout, exp_v); else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] d2;
    int cyc;
    start_xfer(8'd3, 4'b0101, rand_vec(), 1'b1, '0);
    wait_done(1, cyc);
    n_chk++; if (cyc != 15) $display("FAIL b2b_first_cycle: got %0d exp 15", cyc); else n_pass++;
    exp_v = exp_q.pop_front();
    n_chk++; if (dout !== exp_v) $display("FAIL b2b_first_dout: got %h exp %h", dout, exp_v); else n_pass++;
    // start held through FIN (ignored) and the first IDLE cycle (accepted)
    d2 = rand_vec();
    exp_q.push_back(model(d2, 8'd2, 4'b1111, 1'b1, '0));
    num_of_bits = 8'd2; dev_mask = 4'b1111; din = d2; start = 1'b1;
    @(posedge clk); #1;
    n_chk++; if (done !== 1'b0) $display("FAIL b2b_done_width: got %b exp 0", done); else n_pass++;
    n_chk++; if (busy !== 1'b0) $display("FAIL b2b_fin_start_ignored: got busy %b exp 0", busy); else n_pass++;
    @(posedge clk); #1;
    start = 1'b0;
    n_chk++; if (busy !== 1'b1) $display("FAIL b2b_idle_start_taken: got busy %b exp 1", busy); else n_pass++;
    wait_done(1, cyc);
    n_chk++; if (cyc != 11) $display("FAIL b2b_second_cycle: got %0d exp 11", cyc); else n_pass++;
    exp_v = exp_q.pop_front();
    n_chk++; if (dout !== exp_v) $display("FAIL b2b_second_dout: got %h exp %h", dout, exp_v); else n_pass++;
  endtask

  initial begin
    clear_mon('1);
    test_reset();
    test_single_70();
    test_partial_clamp();
    test_masking();
    test_zero_length();
    test_ignored_start();
    test_reset_abort();
    test_back_to_back();
    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
